delay_xfer_sched: RTL
=====================

Name: delay_xfer_sched

Overview:
- Hardware sequencer for delayed register transfers: one request waits a programmed number of cycles, then performs `dst = src`.
- Delay sources:
  - fixed delay from config (D);
  - average of two config delays, (D+E)/2;
  - per-request delay value;
  - zero.
- The source operand is sampled when the delay expires, not when the request is accepted.
- Sits between a control sequencer (request side) and a register file / datapath (transfer side). One operation is outstanding at a time.

Parameters:
- WIDTH, 32, data width of the transferred value
- DW, 8, width of delay values and the remaining-cycle counter
- CW, 16, width of the issued-transfer counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_d  in  DW  delay D, used by mode 0 and mode 1
- cfg_e  in  DW  delay E, used by mode 1
- req_valid  in  1  request valid
- req_ready  out  1  request ready
- req_mode  in  2  0 = D; 1 = (D+E)>>1; 2 = req_delay; 3 = reserved, treated as delay 0 and flagged
- req_delay  in  DW  per-request delay (mode 2)
- abort  in  1  cancel a pending countdown
- src_data  in  WIDTH  transfer source operand
- xfer_valid  out  1  one-cycle pulse: transfer performed
- xfer_data  out  WIDTH  transferred value; holds until the next transfer
- remaining  out  DW  cycles left in the countdown; 0 when not counting
- busy  out  1  high while counting
- aborted  out  1  one-cycle pulse: countdown cancelled
- mode_err  out  1  sticky; set on acceptance of mode 3, cleared only by reset
- xfer_cnt  out  CW  count of issued transfers; wraps modulo 2^CW

Behaviour:
- Reset (async, rst_n=0):
  - state goes to IDLE; remaining=0, busy=0, xfer_valid=0, xfer_data=0, aborted=0, mode_err=0, xfer_cnt=0.
  - Reset during a countdown cancels it silently: no xfer_valid, no aborted pulse.
  - After release, req_ready=1.
- States: IDLE, COUNT, ISSUE. All outputs are registered except req_ready.
- req_ready = (state==IDLE) || (state==ISSUE), combinational from state.
  - Back-to-back requests can be accepted in the ISSUE cycle, so throughput is one transfer per N+1 cycles.
- Acceptance at edge t0 (req_valid & req_ready):
  - Delay N is computed from the mode:
    - mode 0: cfg_d.
    - mode 1: (cfg_d+cfg_e) formed at DW+1 bits, then shifted right by 1 (floor, no overflow; 255+255 gives 255).
    - mode 2: req_delay.
    - mode 3: 0, and mode_err is set.
  - cfg_d, cfg_e and req_delay are sampled only at acceptance; later changes do not affect a pending count.
  - If N>0: next state COUNT, remaining=N, busy=1.
  - If N==0: next state ISSUE.
- COUNT:
  - remaining decrements by 1 each edge.
  - On the edge where remaining==1: next state ISSUE, remaining=0, busy=0.
- Entering ISSUE (edge t0+N):
  - xfer_data <= src_data sampled at that edge;
  - xfer_cnt increments.
  - xfer_valid is high for exactly the cycle in which the state is ISSUE.
  - Latency from the acceptance edge to xfer_data capture is exactly N edges.
- ISSUE exit: next state is IDLE unless a new request is accepted on that edge.
- abort:
  - Honoured only in COUNT: next state IDLE, remaining=0, busy=0, aborted pulses for 1 cycle; no transfer and no xfer_cnt change.
  - If abort arrives on the edge where remaining==1, abort wins.
  - Ignored in IDLE and ISSUE; an ISSUE in progress still completes.
- req_valid while req_ready=0 is ignored; the requester must hold it.
- xfer_cnt wraps from 2^CW-1 to 0.

Test Plan:
- Reset, then mode 2 with req_delay=10 at t0, src_data changing every cycle → xfer_valid pulse only in the cycle after edge t0+10; xfer_data equals src_data at edge t0+10; remaining reads 10,9,…,1 then 0.
- cfg_d=6, cfg_e=9, mode 1 → N=7. Change cfg_d to 1 mid-count → transfer is still at t0+7. Repeat with cfg_d=cfg_e=255 → N=255.
- Mode 0 with cfg_d=0, then a back-to-back mode 3 request accepted in the ISSUE cycle → xfer_valid on two consecutive cycles; mode_err=1 and stays 1; xfer_cnt increments by 2.
- Mode 2, delay 5; assert abort on the edge where remaining==1 → aborted pulse, no xfer_valid, xfer_data and xfer_cnt unchanged, req_ready=1 the next cycle.
- Assert rst_n=0 asynchronously mid-count (remaining=3) → all outputs 0 immediately, no transfer; a new request after release behaves normally.
- Set CW=4 and issue 17 delay-0 transfers → xfer_cnt wraps to 1.

Source files
------------

// File: rtl/delay_xfer_sched_if.sv
// ----------------------------------------------------------------------------
// delay_xfer_sched_if
//   Request-side handshake between the control sequencer and the delayed
//   transfer scheduler.
//
//   Signals
//     req_valid  requester -> scheduler  request valid (held until accepted)
//     req_ready  scheduler -> requester  scheduler can accept a request
//     req_mode   requester -> scheduler  delay source select
//     req_delay  requester -> scheduler  per-request delay (mode 2)
//     abort      requester -> scheduler  cancel a pending countdown
//
//   Modports
//     master  control sequencer side
//     slave   scheduler side
// ----------------------------------------------------------------------------
interface delay_xfer_sched_if #(
    parameter int DW = 8
) ();
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_mode;
    logic [DW-1:0] req_delay;
    logic          abort;

    modport master (
        output req_valid,
        output req_mode,
        output req_delay,
        output abort,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_mode,
        input  req_delay,
        input  abort,
        output req_ready
    );
endinterface

// File: rtl/delay_xfer_sched.sv
// ----------------------------------------------------------------------------
// delay_xfer_sched
//   Sequencer for a single delayed register transfer. A request is accepted,
//   a delay N is chosen from its mode, the block counts N cycles and then
//   copies src_data into xfer_data (dst = src). The source operand is taken
//   when the countdown expires, not when the request is accepted. Only one
//   operation is outstanding at a time; a new request may be accepted in the
//   cycle the transfer is issued.
//
//   Parameters
//     WIDTH  transferred data width
//     DW     delay / remaining-counter width
//     CW     issued-transfer counter width
//
//   Ports
//     clk         clock
//     rst_n       asynchronous active-low reset
//     cfg_d       config delay D (modes 0 and 1)
//     cfg_e       config delay E (mode 1)
//     req         request handshake (slave modport): req_valid, req_ready,
//                 req_mode, req_delay, abort
//     src_data    transfer source operand
//     xfer_valid  one-cycle pulse: transfer performed
//     xfer_data   transferred value, held until the next transfer
//     remaining   cycles left in the countdown, 0 when not counting
//     busy        high while counting
//     aborted     one-cycle pulse: countdown cancelled
//     mode_err    sticky flag: reserved mode 3 was accepted
//     xfer_cnt    number of issued transfers, wraps modulo 2^CW
// ----------------------------------------------------------------------------
module delay_xfer_sched #(
    parameter int WIDTH = 32,
    parameter int DW    = 8,
    parameter int CW    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DW-1:0]        cfg_d,
    input  logic [DW-1:0]        cfg_e,
    delay_xfer_sched_if.slave    req,
    input  logic [WIDTH-1:0]     src_data,
    output logic                 xfer_valid,
    output logic [WIDTH-1:0]     xfer_data,
    output logic [DW-1:0]        remaining,
    output logic                 busy,
    output logic                 aborted,
    output logic                 mode_err,
    output logic [CW-1:0]        xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] remaining_nxt;
    logic [DW-1:0] delay_n;
    logic          bad_mode;
    logic          accept;
    logic          abort_hit;

    // Mean of two delays. The sum is formed one bit wider so that the
    // largest inputs cannot overflow; the halving floors.
    function automatic logic [DW-1:0] avg_delay(input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        logic [DW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return DW'(sum >> 1);
    endfunction

    // Ready in ISSUE as well as IDLE so back-to-back requests lose no cycle.
    assign req.req_ready = (state == IDLE) || (state == ISSUE);
    assign accept        = req.req_valid && req.req_ready;
    assign abort_hit     = (state == COUNT) && req.abort;

    // Delay selection; only meaningful in the cycle a request is accepted.
    always_comb begin
        delay_n  = '0;
        bad_mode = 1'b0;
        case (req.req_mode)
            2'd0:    delay_n = cfg_d;
            2'd1:    delay_n = avg_delay(cfg_d, cfg_e);
            2'd2:    delay_n = req.req_delay;
            default: bad_mode = 1'b1;
        endcase
    end

    // Next-state and countdown.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        case (state)
            IDLE, ISSUE: begin
                state_nxt     = IDLE;
                remaining_nxt = '0;
                if (accept) begin
                    if (delay_n != '0) begin
                        state_nxt     = COUNT;
                        remaining_nxt = delay_n;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            COUNT: begin
                // Abort takes priority even on the final count.
                if (req.abort) begin
                    state_nxt     = IDLE;
                    remaining_nxt = '0;
                end else if (remaining == DW'(1)) begin
                    state_nxt     = ISSUE;
                    remaining_nxt = '0;
                end else begin
                    remaining_nxt = remaining - DW'(1);
                end
            end
            default: begin
                state_nxt     = IDLE;
                remaining_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs, all derived from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining  <= '0;
            busy       <= 1'b0;
            xfer_valid <= 1'b0;
            xfer_data  <= '0;
            aborted    <= 1'b0;
            mode_err   <= 1'b0;
            xfer_cnt   <= '0;
        end else begin
            remaining  <= remaining_nxt;
            busy       <= (state_nxt == COUNT);
            xfer_valid <= (state_nxt == ISSUE);
            aborted    <= abort_hit;
            if (accept && bad_mode) begin
                mode_err <= 1'b1;
            end
            // The operand is sampled on the edge that enters ISSUE.
            if (state_nxt == ISSUE) begin
                xfer_data <= src_data;
                xfer_cnt  <= xfer_cnt + CW'(1);
            end
        end
    end

endmodule
